// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type codes and
// default widths used by both the transmit and receive ends of the link.
package uart_pkg;

  // Default frame geometry, shared with the receive side.
  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_PRESCALE_WIDTH = 5;

  // Parity type selector values.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter. Counts 0..P-1 cycles and
// flags the last cycle of each bit. A prescale of 0 or 1 gives a
// one-cycle bit. The count restarts from zero when a frame is accepted.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] cnt_r;
  logic [PRESCALE_WIDTH-1:0] last_s;
  logic                      at_last_s;

  // Terminal count of one bit period; prescales below 2 collapse to one cycle.
  always_comb begin
    last_s = {PRESCALE_WIDTH{1'b0}};
    if (prescale <= PRESCALE_WIDTH'(1)) begin
      last_s = {PRESCALE_WIDTH{1'b0}};
    end else begin
      last_s = prescale - PRESCALE_WIDTH'(1);
    end
  end

  assign at_last_s = (cnt_r == last_s);
  assign bit_done  = enable & at_last_s;

  // Cycle counter: restarts on frame start, wraps at the end of each bit, idles at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {PRESCALE_WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r <= {PRESCALE_WIDTH{1'b0}};
    end else if (enable) begin
      if (at_last_s) begin
        cnt_r <= {PRESCALE_WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
      end
    end else begin
      cnt_r <= {PRESCALE_WIDTH{1'b0}};
    end
  end

endmodule : uart_tx_bit_timer

// File: rtl/uart_tx.sv
// UART transmitter. Serialises one byte per accepted request as
// start bit, LSB-first data, optional parity bit, stop bit. Every bit
// lasts the prescale value captured with the byte. Tx_OUT and Tx_Busy
// are driven straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      Tx_CLK,
  input  logic                      Tx_RST,
  input  logic [DATA_WIDTH-1:0]     Tx_P_DATA,
  input  logic                      Tx_Data_Valid,
  input  logic [PRESCALE_WIDTH-1:0] Tx_prescale,
  input  logic                      Tx_PAR_EN,
  input  logic                      Tx_PAR_TYP,
  output logic                      Tx_OUT,
  output logic                      Tx_Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  // Parity over the payload: even = XOR of the bits, odd = its inverse.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  par_typ);
    logic x;
    x = ^data;
    return (par_typ == PAR_ODD) ? ~x : x;
  endfunction

  tx_state_e                 state_r, state_s;
  logic [IDX_W-1:0]          idx_r, idx_s;
  logic                      tx_out_r, tx_out_s;
  logic                      busy_r, busy_s;
  logic                      accept_s;
  logic                      bit_done_s;
  logic                      timer_en_s;

  logic [DATA_WIDTH-1:0]     data_r;
  logic                      par_en_r;
  logic                      par_bit_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r;

  assign timer_en_s = (state_r != ST_IDLE);

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk      (Tx_CLK),
    .rst_n    (Tx_RST),
    .clear    (accept_s),
    .enable   (timer_en_s),
    .prescale (prescale_r),
    .bit_done (bit_done_s)
  );

  // Next state, data index and next values of the registered line/busy outputs.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    tx_out_s = tx_out_r;
    busy_s   = busy_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Tx_Data_Valid) begin
          accept_s = 1'b1;
          state_s  = ST_START;
          idx_s    = {IDX_W{1'b0}};
          tx_out_s = 1'b0;
          busy_s   = 1'b1;
        end else begin
          tx_out_s = 1'b1;
          busy_s   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_s  = ST_DATA;
          idx_s    = {IDX_W{1'b0}};
          tx_out_s = data_r[0];
        end else begin
          state_s  = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          if (idx_r == IDX_LAST) begin
            idx_s = {IDX_W{1'b0}};
            if (par_en_r) begin
              state_s  = ST_PARITY;
              tx_out_s = par_bit_r;
            end else begin
              state_s  = ST_STOP;
              tx_out_s = 1'b1;
            end
          end else begin
            idx_s    = idx_r + IDX_W'(1);
            tx_out_s = data_r[idx_s];
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_done_s) begin
          state_s  = ST_STOP;
          tx_out_s = 1'b1;
        end else begin
          state_s  = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          state_s  = ST_IDLE;
          tx_out_s = 1'b1;
          busy_s   = 1'b0;
        end else begin
          state_s  = ST_STOP;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        idx_s    = {IDX_W{1'b0}};
        tx_out_s = 1'b1;
        busy_s   = 1'b0;
      end
    endcase
  end

  // FSM state, data index and registered serial outputs; reset aborts any frame.
  always_ff @(posedge Tx_CLK) begin
    if (!Tx_RST) begin
      state_r  <= ST_IDLE;
      idx_r    <= {IDX_W{1'b0}};
      tx_out_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      tx_out_r <= tx_out_s;
      busy_r   <= busy_s;
    end
  end

  // Frame configuration captured at acceptance so later input changes cannot disturb it.
  always_ff @(posedge Tx_CLK) begin
    if (!Tx_RST) begin
      data_r     <= {DATA_WIDTH{1'b0}};
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      prescale_r <= {PRESCALE_WIDTH{1'b0}};
    end else if (accept_s) begin
      data_r     <= Tx_P_DATA;
      par_en_r   <= Tx_PAR_EN;
      par_bit_r  <= calc_parity(Tx_P_DATA, Tx_PAR_TYP);
      prescale_r <= Tx_prescale;
    end else begin
      data_r     <= data_r;
      par_en_r   <= par_en_r;
      par_bit_r  <= par_bit_r;
      prescale_r <= prescale_r;
    end
  end

  assign Tx_OUT  = tx_out_r;
  assign Tx_Busy = busy_r;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A behavioural model builds each
// expected frame as a list of line levels from the byte, parity
// settings and prescale, and every cycle of the line and busy flag is
// compared against it. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          Tx_CLK = 1'b0;
  logic          Tx_RST = 1'b0;
  logic [DW-1:0] Tx_P_DATA = '0;
  logic          Tx_Data_Valid = 1'b0;
  logic [PW-1:0] Tx_prescale = '0;
  logic          Tx_PAR_EN = 1'b0;
  logic          Tx_PAR_TYP = 1'b0;
  logic          Tx_OUT;
  logic          Tx_Busy;

  int total_cnt = 0;
  int bad_cnt   = 0;

  bit         exp_bits[$];
  logic [7:0] mid_data   = 8'h00;
  bit         scramble   = 1'b0;
  bit         hold_valid = 1'b0;

  uart_tx #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .Tx_CLK        (Tx_CLK),
    .Tx_RST        (Tx_RST),
    .Tx_P_DATA     (Tx_P_DATA),
    .Tx_Data_Valid (Tx_Data_Valid),
    .Tx_prescale   (Tx_prescale),
    .Tx_PAR_EN     (Tx_PAR_EN),
    .Tx_PAR_TYP    (Tx_PAR_TYP),
    .Tx_OUT        (Tx_OUT),
    .Tx_Busy       (Tx_Busy)
  );

  // 10-unit clock.
  always #5 Tx_CLK = ~Tx_CLK;

  // Run-time guard so the bench can never hang.
  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line levels of one frame, one entry per bit.
  task automatic build_frame(input logic [7:0] d, input bit pe, input bit pt);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
    if (pe) exp_bits.push_back(bit'(($countones(d) % 2) ^ int'(pt)));
    exp_bits.push_back(1'b1);
  endtask

  // Present a request for one cycle; returns at the falling edge after acceptance.
  task automatic start_frame(input logic [7:0] d, input int p, input bit pe, input bit pt);
    Tx_P_DATA     = d;
    Tx_prescale   = PW'(p);
    Tx_PAR_EN     = pe;
    Tx_PAR_TYP    = pt;
    Tx_Data_Valid = 1'b1;
    @(negedge Tx_CLK);
  endtask

  // Check up to stop_after cycles of a frame that was just accepted.
  task automatic check_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                             input int stop_after);
    int pe_eff;
    int n;
    pe_eff = (p < 2) ? 1 : p;
    build_frame(d, pe, pt);
    n = exp_bits.size() * pe_eff;
    for (int k = 0; k < n && k < stop_after; k++) begin
      chk("tx_out", {31'd0, Tx_OUT}, {31'd0, exp_bits[k / pe_eff]});
      chk("busy",   {31'd0, Tx_Busy}, 32'd1);
      Tx_P_DATA     = mid_data;
      Tx_Data_Valid = hold_valid;
      if (scramble) begin
        Tx_prescale = PW'($urandom_range(0, 31));
        Tx_PAR_EN   = 1'($urandom_range(0, 1));
        Tx_PAR_TYP  = 1'($urandom_range(0, 1));
      end
      @(negedge Tx_CLK);
    end
  endtask

  // Line must idle high and not busy for cnt cycles.
  task automatic check_idle(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      chk("idle_out",  {31'd0, Tx_OUT}, 32'd1);
      chk("idle_busy", {31'd0, Tx_Busy}, 32'd0);
      @(negedge Tx_CLK);
    end
  endtask

  task automatic one_frame(input logic [7:0] d, input int p, input bit pe, input bit pt);
    start_frame(d, p, pe, pt);
    Tx_Data_Valid = 1'b0;
    check_frame(d, p, pe, pt, 1 << 30);
    check_idle(2);
  endtask

  initial begin
    logic [7:0] rd;
    int         rp;
    bit         rpe, rpt;

    // Reset, then idle.
    repeat (3) @(negedge Tx_CLK);
    Tx_RST = 1'b1;
    check_idle(20);

    // 0xA5, prescale 8, no parity; inputs scrambled mid-frame.
    scramble = 1'b1;
    mid_data = 8'h5A;
    one_frame(8'hA5, 8, 1'b0, 1'b0);

    // 0xA5, prescale 16, even and odd parity.
    one_frame(8'hA5, 16, 1'b1, 1'b0);
    one_frame(8'hA5, 16, 1'b1, 1'b1);

    // 0x07, odd parity, data input forced to 0xFF during the frame.
    mid_data = 8'hFF;
    one_frame(8'h07, 8, 1'b1, 1'b1);

    // Valid held high: 0x3C then 0xC3, one idle cycle between, no repeat.
    scramble   = 1'b0;
    hold_valid = 1'b1;
    mid_data   = 8'hC3;
    start_frame(8'h3C, 8, 1'b0, 1'b0);
    check_frame(8'h3C, 8, 1'b0, 1'b0, 1 << 30);
    check_idle(1);
    hold_valid = 1'b0;
    check_frame(8'hC3, 8, 1'b0, 1'b0, 1 << 30);
    check_idle(20);

    // Reset during data bit 3 aborts the frame, then a clean frame follows.
    scramble = 1'b1;
    mid_data = 8'h00;
    start_frame(8'h96, 4, 1'b1, 1'b0);
    Tx_Data_Valid = 1'b0;
    check_frame(8'h96, 4, 1'b1, 1'b0, 17);
    Tx_RST = 1'b0;
    @(negedge Tx_CLK);
    chk("rst_out",  {31'd0, Tx_OUT}, 32'd1);
    chk("rst_busy", {31'd0, Tx_Busy}, 32'd0);
    Tx_RST = 1'b1;
    Tx_Data_Valid = 1'b0;
    check_idle(10);
    one_frame(8'h69, 6, 1'b1, 1'b1);

    // Randomized frames, including prescale 0 and 1.
    for (int f = 0; f < 24; f++) begin
      rd  = 8'($urandom_range(0, 255));
      rp  = (f < 2) ? f : int'($urandom_range(0, 12));
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      mid_data = 8'($urandom_range(0, 255));
      one_frame(rd, rp, rpe, rpt);
      check_idle(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule : tb_uart_tx
